// File: rtl/key_conditioner_pkg.sv
// Shared encodings and default timing constants for the key conditioner
// and the stopwatch time-base logic.
package key_conditioner_pkg;

    typedef enum logic [1:0] {
        KC_IDLE  = 2'd0,
        KC_ARMED = 2'd1,
        KC_HELD  = 2'd2
    } kcState_t;

    localparam int CLK_HZ  = 50_000_000;
    localparam int DB_MS   = 10;
    localparam int HOLD_MS = 1000;

    function automatic int msToCycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stability-counter debounce for one raw key.
// Strobes fire on the same edge the debounced level changes.
module key_debounce #(
    parameter int   DB_CYCLES = 500_000,
    parameter logic RST_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic riseStb,
    output logic fallStb
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          dbLevel;
    logic [CW-1:0] dbCnt;
    logic          differ;
    logic          accept;

    assign differ = (sync2 != dbLevel);
    assign accept = differ && (dbCnt == CW'(DB_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= RST_VAL;
            sync2   <= RST_VAL;
            dbLevel <= RST_VAL;
            dbCnt   <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            // any return to the accepted level restarts the stability window
            if (!differ) begin
                dbCnt <= '0;
            end else if (accept) begin
                dbLevel <= sync2;
                dbCnt   <= '0;
            end else if (dbCnt != '1) begin
                dbCnt <= dbCnt + 1'b1;
            end
        end
    end

    assign level   = dbLevel;
    assign riseStb = accept &&  sync2;
    assign fallStb = accept && !sync2;

endmodule

// File: rtl/key_conditioner.sv
// Input front end for the stopwatch core: debounced StartStop short/long
// press events and debounced ModeSel level with change pulse.
//
// state    | meaning
// KC_IDLE  | button released, waiting for a debounced press
// KC_ARMED | pressed, timing the hold; release gives start_stop_pulse
// KC_HELD  | long press already reported, waiting for release
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int DB_CYCLES   = msToCycles(DB_MS),
    parameter int HOLD_CYCLES = msToCycles(HOLD_MS)
) (
    input  logic CLK_50MHz,
    input  logic rst,
    input  logic StartStop,
    input  logic ModeSel,
    output logic start_stop_pulse,
    output logic clear_pulse,
    output logic mode_level,
    output logic mode_change_pulse
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    kcState_t      state;
    kcState_t      stateNxt;
    logic [HW-1:0] holdCnt;
    logic [HW-1:0] holdCntNxt;
    logic          ssLevel;
    logic          ssRise;
    logic          ssFall;
    logic          modeDb;
    logic          modeRise;
    logic          modeFall;
    logic          pressStb;
    logic          releaseStb;
    logic          pressed;
    logic          holdDone;
    logic          ssPulseNxt;
    logic          clrPulseNxt;

    key_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .RST_VAL   (1'b1)
    ) uStart (
        .clk     (CLK_50MHz),
        .rst     (rst),
        .pin     (StartStop),
        .level   (ssLevel),
        .riseStb (ssRise),
        .fallStb (ssFall)
    );

    key_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .RST_VAL   (1'b0)
    ) uMode (
        .clk     (CLK_50MHz),
        .rst     (rst),
        .pin     (ModeSel),
        .level   (modeDb),
        .riseStb (modeRise),
        .fallStb (modeFall)
    );

    // StartStop is active-low: a debounced fall is a press
    assign pressStb   = ssFall;
    assign releaseStb = ssRise;
    assign pressed    = ~ssLevel;
    assign holdDone   = (holdCnt == HW'(HOLD_CYCLES - 1));

    always_ff @(posedge CLK_50MHz or posedge rst) begin
        if (rst) begin
            state            <= KC_IDLE;
            holdCnt          <= '0;
            start_stop_pulse <= 1'b0;
            clear_pulse      <= 1'b0;
        end else begin
            state            <= stateNxt;
            holdCnt          <= holdCntNxt;
            start_stop_pulse <= ssPulseNxt;
            clear_pulse      <= clrPulseNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        case (state)
            KC_IDLE:  if (pressStb) stateNxt = KC_ARMED;
            KC_ARMED: begin
                if (releaseStb)    stateNxt = KC_IDLE;
                else if (holdDone) stateNxt = KC_HELD;
            end
            KC_HELD:  if (releaseStb) stateNxt = KC_IDLE;
            default:  stateNxt = KC_IDLE;
        endcase
    end

    // release and hold threshold on the same edge: release wins
    always_comb begin
        ssPulseNxt  = 1'b0;
        clrPulseNxt = 1'b0;
        holdCntNxt  = holdCnt;
        case (state)
            KC_IDLE: begin
                if (pressStb) holdCntNxt = '0;
            end
            KC_ARMED: begin
                ssPulseNxt  = releaseStb;
                clrPulseNxt = holdDone && !releaseStb;
                if (pressed && (holdCnt != '1)) holdCntNxt = holdCnt + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_50MHz or posedge rst) begin
        if (rst) begin
            mode_level        <= 1'b0;
            mode_change_pulse <= 1'b0;
        end else begin
            mode_level        <= (modeDb | modeRise) & ~modeFall;
            mode_change_pulse <= modeRise | modeFall;
        end
    end

endmodule
